stereo_addsub_sched: RTL and testbench
======================================

# stereo_addsub_sched

Scheduler that time-multiplexes one shared add/subtract unit to rebuild stereo left/right channels from the demodulated L+R and L−R sample FIFOs. It pops one sample from each input FIFO as a pair, writes `left = (L+R) + (L−R)` to the left output FIFO, then writes `right = (L+R) − (L−R)` to the right output FIFO. It sits after the stereo demodulation/de-emphasis stages and before the audio output FIFOs. Fetch of the next pair overlaps the right-channel write, so sustained throughput is one stereo sample per 2 cycles.

## Interface
- DATA_WIDTH, 32, width of every sample (two's complement)
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- sum_dout  in  DATA_WIDTH  L+R FIFO head (first-word-fall-through, valid while !sum_empty)
- sum_empty  in  1  L+R FIFO empty
- sum_rd_en  out  1  pop L+R FIFO
- diff_dout  in  DATA_WIDTH  L−R FIFO head (first-word-fall-through)
- diff_empty  in  1  L−R FIFO empty
- diff_rd_en  out  1  pop L−R FIFO
- left_din  out  DATA_WIDTH  left sample
- left_full  in  1  left FIFO full
- left_wr_en  out  1  left FIFO write strobe
- right_din  out  DATA_WIDTH  right sample
- right_full  in  1  right FIFO full
- right_wr_en  out  1  right FIFO write strobe
- sample_count  out  16  stereo samples completed, wraps 0xFFFF→0

## Operation
- Registers: state, a_reg (latched L+R), b_reg (latched L−R), sample_count. All reset to 0; state resets to S_FETCH.
- Shared ALU computes `a_reg + b_reg` or `a_reg − b_reg`, full DATA_WIDTH, modulo 2^DATA_WIDTH wrap. No saturation and no scaling.
- S_FETCH: if !sum_empty && !diff_empty, assert sum_rd_en and diff_rd_en together, latch a_reg←sum_dout and b_reg←diff_dout, and go to S_LEFT. Otherwise hold. Never pop one FIFO without the other.
- S_LEFT: if !left_full, set op=ADD, left_din=ALU result, left_wr_en=1, and go to S_RIGHT. Otherwise hold with no strobes.
- S_RIGHT: if !right_full, set op=SUB, right_din=ALU result, right_wr_en=1, and increment sample_count.
  - If both inputs are also non-empty in the same cycle, pop both, latch the new pair (after the ALU output is sampled), and go to S_LEFT.
  - Otherwise go to S_FETCH.
  - If right_full, hold with no strobes and no pops.
- Illegal state: return to S_FETCH, no strobes.
- left_din and right_din are 0 whenever their wr_en is low.
- All strobes are combinational from state and the full/empty flags. At most one output write per cycle.

## Timing
- After reset deassert, all outputs are 0 and sample_count is 0.
- Latency: pop in cycle N, left write in N+1, right write in N+2 (no back-pressure).
- Sustained rate: 2 cycles per stereo sample when inputs are non-empty and outputs are not full.
- Back-pressure: a full output stalls in place. a_reg/b_reg hold and no input is consumed until the pending write completes.
- Left is always written before right for the same pair. Output FIFOs therefore stay sample-aligned.
- Reset mid-operation: a pending latched pair is discarded and not written. A pair already popped is lost, which is accepted.
- sample_count increments exactly on each right_wr_en cycle.

## Structure
- Package stereo_pkg holds:
  - state_t {S_FETCH, S_LEFT, S_RIGHT}
  - op_t {OP_ADD, OP_SUB}
  - the COUNT_WIDTH=16 constant
- One sub-module, addsub_alu: combinational, parameter DATA_WIDTH, inputs a, b, op, output y. It is instantiated once and is the only arithmetic in the block.
- Top module contains only the FSM, pair registers and counter.

## Test plan
- Reset: assert reset mid-stream with a pair latched in S_LEFT → all outputs 0, sample_count 0, no write of the latched pair after release.
- Basic: sum=10, diff=4 → left_din=14 one cycle after pop, right_din=6 the next cycle, sample_count=1.
- Signed/wrap:
  - sum=0xFFFFFFFD (−3), diff=5 → left 2, right 0xFFFFFFF8.
  - sum=0x7FFFFFFF, diff=1 → left 0x80000000, right 0x7FFFFFFE.
- Back-pressure: hold left_full for 5 cycles in S_LEFT, then right_full for 3 cycles → no strobes or pops while full, then correct values, order preserved.
- Unbalanced input: sum non-empty, diff empty for 10 cycles → no pops on either FIFO. Diff arrives → both pop in the same cycle.
- Streaming: 1000 random pairs, random full/empty throttling, scoreboard left=a+b and right=a−b mod 2^32. With no throttling, 8 pairs complete in 16 cycles. Also preload sample_count to 0xFFFF → next sample wraps it to 0.

Source files
------------

// File: rtl/stereo_addsub_sched_pkg.sv
// rtl/stereo_addsub_sched_pkg.sv - shared types and constants for the stereo add/sub scheduler
package stereo_pkg;

    localparam int COUNT_WIDTH = 16;

    typedef logic [1:0] state_t;
    localparam state_t S_FETCH = 2'd0;
    localparam state_t S_LEFT  = 2'd1;
    localparam state_t S_RIGHT = 2'd2;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

endpackage

// File: rtl/stereo_addsub_sched_if.sv
// rtl/stereo_addsub_sched_if.sv - FIFO-side signal bundle for the stereo add/sub scheduler
interface stereo_addsub_sched_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0] sum_dout;
    logic                  sum_empty;
    logic                  sum_rd_en;
    logic [DATA_WIDTH-1:0] diff_dout;
    logic                  diff_empty;
    logic                  diff_rd_en;
    logic [DATA_WIDTH-1:0] left_din;
    logic                  left_full;
    logic                  left_wr_en;
    logic [DATA_WIDTH-1:0] right_din;
    logic                  right_full;
    logic                  right_wr_en;

    modport master (
        input  sum_dout, sum_empty, diff_dout, diff_empty, left_full, right_full,
        output sum_rd_en, diff_rd_en, left_din, left_wr_en, right_din, right_wr_en
    );

    modport slave (
        output sum_dout, sum_empty, diff_dout, diff_empty, left_full, right_full,
        input  sum_rd_en, diff_rd_en, left_din, left_wr_en, right_din, right_wr_en
    );
endinterface

// File: rtl/stereo_addsub_sched_alu.sv
// rtl/stereo_addsub_sched_alu.sv - shared combinational add/subtract unit, modulo 2^DATA_WIDTH
module addsub_alu
    import stereo_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  op_t                   op,
    output logic [DATA_WIDTH-1:0] y
);
    assign y = (op == OP_SUB) ? (a - b) : (a + b);
endmodule

// File: rtl/stereo_addsub_sched.sv
// rtl/stereo_addsub_sched.sv - rebuilds left/right from L+R and L-R through one shared add/sub unit
module stereo_addsub_sched
    import stereo_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    stereo_addsub_sched_if.master  fifo,
    output logic [COUNT_WIDTH-1:0] sample_count
);
    state_t                 state, state_next;
    logic [DATA_WIDTH-1:0]  a_reg, b_reg;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [DATA_WIDTH-1:0]  alu_y;
    op_t                    op;
    logic                   pop, load, left_wr, right_wr, inc;
    logic                   inputs_ready;

    assign inputs_ready = !fifo.sum_empty && !fifo.diff_empty;

    addsub_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .a  (a_reg),
        .b  (b_reg),
        .op (op),
        .y  (alu_y)
    );

    always_comb begin
        state_next = state;
        op         = OP_ADD;
        pop        = 1'b0;
        load       = 1'b0;
        left_wr    = 1'b0;
        right_wr   = 1'b0;
        inc        = 1'b0;
        case (state)
            S_FETCH: begin
                if (inputs_ready) begin
                    pop        = 1'b1;
                    load       = 1'b1;
                    state_next = S_LEFT;
                end
            end
            S_LEFT: begin
                if (!fifo.left_full) begin
                    op         = OP_ADD;
                    left_wr    = 1'b1;
                    state_next = S_RIGHT;
                end
            end
            S_RIGHT: begin
                // Next pair is fetched while the right sample is written, giving 2 cycles/sample.
                if (!fifo.right_full) begin
                    op       = OP_SUB;
                    right_wr = 1'b1;
                    inc      = 1'b1;
                    if (inputs_ready) begin
                        pop        = 1'b1;
                        load       = 1'b1;
                        state_next = S_LEFT;
                    end else begin
                        state_next = S_FETCH;
                    end
                end
            end
            default: state_next = S_FETCH;
        endcase
    end

    assign fifo.sum_rd_en   = pop;
    assign fifo.diff_rd_en  = pop;
    assign fifo.left_wr_en  = left_wr;
    assign fifo.right_wr_en = right_wr;
    assign fifo.left_din    = left_wr ? alu_y : '0;
    assign fifo.right_din   = right_wr ? alu_y : '0;
    assign sample_count     = count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_FETCH;
            a_reg   <= '0;
            b_reg   <= '0;
            count_q <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                a_reg <= fifo.sum_dout;
                b_reg <= fifo.diff_dout;
            end
            if (inc) begin
                count_q <= count_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_stereo_addsub_sched.sv
// tb/tb_stereo_addsub_sched.sv - scoreboard bench for stereo_addsub_sched
module tb_stereo_addsub_sched;
    import stereo_pkg::*;

    localparam int DW = 32;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] sample_count;

    stereo_addsub_sched_if #(.DATA_WIDTH(DW)) bus ();

    stereo_addsub_sched #(.DATA_WIDTH(DW)) dut (
        .clock        (clock),
        .reset        (reset),
        .fifo         (bus.master),
        .sample_count (sample_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [31:0] sum_q[$];
    logic [31:0] diff_q[$];
    logic [31:0] exp_l[$];
    logic [31:0] exp_r[$];
    bit          force_se = 1'b0;
    bit          force_de = 1'b0;
    bit          mon_pop = 1'b0;
    int          pending = 0;
    bit          left_pending = 1'b0;
    logic [15:0] exp_count = 16'd0;
    int          cyc = 0;
    int          n_pop = 0;
    int          n_left = 0;
    int          n_right = 0;
    int          last_pop_cyc = 0;
    int          last_left_cyc = 0;
    int          last_right_cyc = 0;
    int          first_pop_cyc = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic fail(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Model input FIFOs: first-word-fall-through heads, garbage when empty.
    task automatic drive();
        bus.sum_empty  = force_se || (sum_q.size() == 0);
        bus.diff_empty = force_de || (diff_q.size() == 0);
        bus.sum_dout   = (sum_q.size() == 0) ? 32'hDEADBEEF : sum_q[0];
        bus.diff_dout  = (diff_q.size() == 0) ? 32'hBAADF00D : diff_q[0];
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        if (mon_pop) begin
            if (sum_q.size() > 0) void'(sum_q.pop_front());
            if (diff_q.size() > 0) void'(diff_q.pop_front());
        end
        mon_pop = 1'b0;
        drive();
    endtask

    task automatic push_pair(input logic [31:0] s, input logic [31:0] d,
                             input logic [31:0] l, input logic [31:0] r);
        sum_q.push_back(s);
        diff_q.push_back(d);
        exp_l.push_back(l);
        exp_r.push_back(r);
        drive();
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_r.size() > 0 && n < budget) begin
            step();
            n++;
        end
        if (exp_r.size() > 0) fail(name, "timeout waiting for outputs");
        step();
    endtask

    task automatic do_reset();
        sum_q.delete();
        diff_q.delete();
        exp_l.delete();
        exp_r.delete();
        force_se = 1'b0;
        force_de = 1'b0;
        mon_pop  = 1'b0;
        reset    = 1'b1;
        drive();
        repeat (3) step();
        reset = 1'b0;
    endtask

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            chk("rst_sum_rd", 32'(bus.sum_rd_en), 32'd0);
            chk("rst_diff_rd", 32'(bus.diff_rd_en), 32'd0);
            chk("rst_left_wr", 32'(bus.left_wr_en), 32'd0);
            chk("rst_right_wr", 32'(bus.right_wr_en), 32'd0);
            chk("rst_left_din", bus.left_din, 32'd0);
            chk("rst_right_din", bus.right_din, 32'd0);
            chk("rst_count", 32'(sample_count), 32'd0);
            pending      = 0;
            left_pending = 1'b0;
            exp_count    = 16'd0;
            mon_pop      = 1'b0;
        end else begin
            chk("count", 32'(sample_count), 32'(exp_count));
            chk("pop_pair", 32'(bus.sum_rd_en), 32'(bus.diff_rd_en));
            chk("one_write", 32'(bus.left_wr_en & bus.right_wr_en), 32'd0);
            if (!bus.left_wr_en) chk("left_din_idle", bus.left_din, 32'd0);
            if (!bus.right_wr_en) chk("right_din_idle", bus.right_din, 32'd0);
            if (bus.sum_rd_en || bus.diff_rd_en) begin
                chk("pop_nonempty", 32'(bus.sum_empty | bus.diff_empty), 32'd0);
                chk("pop_allowed", 32'(pending == 0 || (pending == 1 && bus.right_wr_en)), 32'd1);
                mon_pop = 1'b1;
                n_pop++;
                last_pop_cyc = cyc;
                if (first_pop_cyc < 0) first_pop_cyc = cyc;
            end
            if (bus.left_wr_en) begin
                chk("left_not_full", 32'(bus.left_full), 32'd0);
                chk("left_order", 32'(left_pending), 32'd0);
                chk("left_has_pair", 32'(pending), 32'd1);
                if (exp_l.size() == 0) fail("left_unexpected", "write with no pair outstanding");
                else chk("left_din", bus.left_din, exp_l.pop_front());
                left_pending = 1'b1;
                n_left++;
                last_left_cyc = cyc;
            end
            if (bus.right_wr_en) begin
                chk("right_not_full", 32'(bus.right_full), 32'd0);
                chk("right_order", 32'(left_pending), 32'd1);
                if (exp_r.size() == 0) fail("right_unexpected", "write with no pair outstanding");
                else chk("right_din", bus.right_din, exp_r.pop_front());
                left_pending = 1'b0;
                exp_count++;
                pending--;
                n_right++;
                last_right_cyc = cyc;
            end
            if (bus.sum_rd_en || bus.diff_rd_en) pending++;
        end
    end

    initial begin
        int base_pop, base_left, base_right, n, pushed;
        logic [31:0] a, b;

        bus.left_full  = 1'b0;
        bus.right_full = 1'b0;
        drive();
        repeat (3) step();
        reset = 1'b0;
        step();

        // Basic pair and latency
        push_pair(32'd10, 32'd4, 32'd14, 32'd6);
        drain("basic", 20);
        chk("lat_left", 32'(last_left_cyc - last_pop_cyc), 32'd1);
        chk("lat_right", 32'(last_right_cyc - last_pop_cyc), 32'd2);
        chk("basic_count", 32'(sample_count), 32'd1);

        // Signed and wrap cases
        push_pair(32'hFFFFFFFD, 32'd5, 32'd2, 32'hFFFFFFF8);
        push_pair(32'h7FFFFFFF, 32'd1, 32'h80000000, 32'h7FFFFFFE);
        drain("wrap", 30);

        // Back-pressure: left stall, then right stall with a second pair waiting
        base_pop = n_pop;
        base_left = n_left;
        base_right = n_right;
        bus.left_full = 1'b1;
        push_pair(32'd100, 32'd30, 32'd130, 32'd70);
        push_pair(32'd7, 32'd9, 32'd16, 32'hFFFFFFFE);
        n = 0;
        while (n_pop == base_pop && n < 10) begin step(); n++; end
        repeat (5) step();
        chk("bp_left_held", 32'(n_left - base_left), 32'd0);
        chk("bp_left_nopop", 32'(n_pop - base_pop), 32'd1);
        bus.left_full  = 1'b0;
        bus.right_full = 1'b1;
        step();
        repeat (3) step();
        chk("bp_left_done", 32'(n_left - base_left), 32'd1);
        chk("bp_right_held", 32'(n_right - base_right), 32'd0);
        chk("bp_right_nopop", 32'(n_pop - base_pop), 32'd1);
        bus.right_full = 1'b0;
        drain("bp", 30);

        // Unbalanced: sum present, diff absent
        base_pop = n_pop;
        sum_q.push_back(32'd50);
        exp_l.push_back(32'd70);
        exp_r.push_back(32'd30);
        drive();
        repeat (10) step();
        chk("unbal_nopop", 32'(n_pop - base_pop), 32'd0);
        diff_q.push_back(32'd20);
        drive();
        drain("unbal", 20);
        chk("unbal_popped", 32'(n_pop - base_pop), 32'd1);

        // Throughput: 8 preloaded pairs, no throttling
        force_se = 1'b1;
        drive();
        for (int i = 0; i < 8; i++) begin
            a = 32'(i * 3 + 1);
            b = 32'(i);
            push_pair(a, b, a + b, a - b);
        end
        step();
        first_pop_cyc = -1;
        force_se = 1'b0;
        drive();
        drain("thru", 40);
        chk("thru_cycles", 32'(last_right_cyc - first_pop_cyc), 32'd16);

        // Counter wrap from 0xFFFF
        force dut.count_q = 16'hFFFF;
        exp_count = 16'hFFFF;
        step();
        release dut.count_q;
        step();
        push_pair(32'd1, 32'd1, 32'd2, 32'd0);
        drain("wrap_cnt", 20);
        chk("count_wrapped", 32'(sample_count), 32'd0);

        // Random streaming with throttling
        base_right = n_right;
        pushed = 0;
        n = 0;
        while ((pushed < 1000 || exp_r.size() > 0) && n < 30000) begin
            if (pushed < 1000 && sum_q.size() < 4 && ($urandom % 4) != 0) begin
                a = $urandom;
                b = $urandom;
                push_pair(a, b, a + b, a - b);
                pushed++;
            end
            bus.left_full  = (($urandom % 4) == 0);
            bus.right_full = (($urandom % 4) == 0);
            force_se       = (($urandom % 8) == 0);
            force_de       = (($urandom % 8) == 0);
            step();
            n++;
        end
        if (exp_r.size() > 0) fail("stream", "timeout waiting for outputs");
        bus.left_full  = 1'b0;
        bus.right_full = 1'b0;
        force_se = 1'b0;
        force_de = 1'b0;
        step();
        step();
        chk("stream_count", 32'(n_right - base_right), 32'd1000);

        // Reset with a pair latched and stalled in the left stage
        base_pop = n_pop;
        bus.left_full = 1'b1;
        push_pair(32'd11, 32'd22, 32'd33, 32'hFFFFFFF5);
        repeat (4) step();
        chk("rst_pair_latched", 32'(n_pop - base_pop), 32'd1);
        do_reset();
        bus.left_full = 1'b0;
        base_left = n_left;
        repeat (6) step();
        chk("rst_no_stale_write", 32'(n_left - base_left), 32'd0);
        chk("rst_count_after", 32'(sample_count), 32'd0);

        push_pair(32'd3, 32'd2, 32'd5, 32'd1);
        drain("post_rst", 20);
        chk("post_rst_count", 32'(sample_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
